// File: rtl/grid_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NREQ requesters, with an
// optional ownership lock for atomic check-then-claim. Define ARB_LOCK_TIMEOUT_EN to add a HOLD idle timeout.
module grid_mem_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 64
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_req_we,
  input  logic [NREQ-1:0]    i_req_lock,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_wdata,
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_rvalid,
  output logic [DW-1:0]      o_rdata,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic [AW-1:0]      o_mem_addr,
  output logic [DW-1:0]      o_mem_din,
  input  logic [DW-1:0]      i_mem_dout,
  output logic               o_owner_busy,
  output logic               o_lock_err,
  output logic [2:0]         o_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HOLD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_RWAIT = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  // Handshake: a requester holds req and its op fields stable until its one-cycle gnt
  // pulse; the op is latched in the decision cycle and never re-sampled afterwards.
  logic [2:0]    r_state;
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] r_owner;
  logic          r_owner_busy;
  logic [PW-1:0] r_idx;
  logic          r_we;
  logic          r_lock;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic [2:0]    r_rd_cnt;

  logic          w_pick_found;
  logic [PW-1:0] w_pick_idx;
  logic          w_sel_valid;
  logic [PW-1:0] w_sel_idx;
  logic          w_sel_we;
  logic          w_sel_lock;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_done;
  logic          w_timeout;
  logic [PW-1:0] w_idx_next;
  logic [PW-1:0] w_owner_next;

  always_comb begin
    int j;
    j            = 0;
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(r_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!w_pick_found && i_req[j]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = PW'(j);
      end
    end
    // While a lock is held only the owner may be served.
    if (r_state == S_HOLD) begin
      w_sel_idx   = r_owner;
      w_sel_valid = i_req[r_owner];
    end else begin
      w_sel_idx   = w_pick_idx;
      w_sel_valid = w_pick_found && (r_state == S_IDLE);
    end
    w_sel_we    = 1'b0;
    w_sel_lock  = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_sel_idx == PW'(k)) begin
        w_sel_we    = i_req_we[k];
        w_sel_lock  = i_req_lock[k];
        w_sel_addr  = i_req_addr[k*AW +: AW];
        w_sel_wdata = i_req_wdata[k*DW +: DW];
      end
    end
  end

  assign w_done       = ((r_state == S_ISSUE) && r_we) || (r_state == S_RESP);
  assign w_idx_next   = (r_idx == PW'(NREQ-1)) ? '0 : r_idx + PW'(1);
  assign w_owner_next = (r_owner == PW'(NREQ-1)) ? '0 : r_owner + PW'(1);

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int LCW = $clog2(LOCK_MAX + 1);
  logic [LCW-1:0] r_lock_cnt;

  assign w_timeout  = (r_state == S_HOLD) && (r_lock_cnt == LCW'(LOCK_MAX));
  assign o_lock_err = w_timeout;

  // Counts owner-idle HOLD cycles; any grant or leaving HOLD clears it.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_lock_cnt <= '0;
    end else if ((r_state == S_HOLD) && !w_timeout && !w_sel_valid) begin
      r_lock_cnt <= r_lock_cnt + LCW'(1);
    end else begin
      r_lock_cnt <= '0;
    end
  end
`else
  assign w_timeout  = 1'b0;
  // LOCK_MAX only matters with the timeout; this expression is always 0 for legal values.
  assign o_lock_err = (LOCK_MAX < 0);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_owner_busy <= 1'b0;
      r_idx        <= '0;
      r_we         <= 1'b0;
      r_lock       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_rd_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HOLD: begin
          if (w_timeout) begin
            r_state      <= S_IDLE;
            r_owner_busy <= 1'b0;
            r_ptr        <= w_owner_next;
          end else if (w_sel_valid) begin
            r_idx   <= w_sel_idx;
            r_we    <= w_sel_we;
            r_lock  <= w_sel_lock;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!r_we) begin
            r_rd_cnt <= '0;
            r_state  <= S_RWAIT;
          end
        end
        S_RWAIT: begin
          if (r_rd_cnt == 3'(RD_LAT-1)) begin
            r_rdata <= i_mem_dout;
            r_state <= S_RESP;
          end else begin
            r_rd_cnt <= r_rd_cnt + 3'd1;
          end
        end
        default: ;
      endcase
      if (w_done) begin
        if (r_lock) begin
          r_owner      <= r_idx;
          r_owner_busy <= 1'b1;
          r_state      <= S_HOLD;
        end else begin
          r_owner_busy <= 1'b0;
          r_ptr        <= w_idx_next;
          r_state      <= S_IDLE;
        end
      end
    end
  end

  always_comb begin
    o_gnt    = '0;
    o_rvalid = '0;
    for (int k = 0; k < NREQ; k++) begin
      o_gnt[k]    = (r_state == S_ISSUE) && (r_idx == PW'(k));
      o_rvalid[k] = (r_state == S_RESP) && (r_idx == PW'(k));
    end
  end

  assign o_mem_read   = (r_state == S_ISSUE) && !r_we;
  assign o_mem_write  = (r_state == S_ISSUE) && r_we;
  assign o_mem_addr   = (r_state == S_ISSUE) ? r_addr : '0;
  assign o_mem_din    = ((r_state == S_ISSUE) && r_we) ? r_wdata : '0;
  assign o_rdata      = r_rdata;
  assign o_owner_busy = r_owner_busy;
  assign o_state      = r_state;

endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Directed bench for grid_mem_arbiter: 4 requesters, RD_LAT=1, LOCK_MAX=8, with a behavioural
// single-port memory; one task per scenario with inline checks.
module tb_grid_mem_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req, req_we, req_lock;
  logic [127:0] req_addr, req_wdata;
  logic [3:0]   gnt, rvalid;
  logic [31:0]  rdata, mem_addr, mem_din, mem_dout;
  logic         mem_read, mem_write, owner_busy, lock_err;
  logic [2:0]   state;

  logic [31:0]  mem [0:255];
  logic         bk_we;
  logic [7:0]   bk_addr;
  logic [31:0]  bk_data;

  int n_cmp = 0;
  int n_bad = 0;
  int g_idx [8];
  int g_cyc [8];
  logic [31:0] g_din [8];
  int n_g;

  grid_mem_arbiter #(
    .NREQ(4), .AW(32), .DW(32), .RD_LAT(1), .LOCK_MAX(8)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_req(req), .i_req_we(req_we), .i_req_lock(req_lock),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_gnt(gnt), .o_rvalid(rvalid),
    .o_rdata(rdata), .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
    .o_mem_din(mem_din), .i_mem_dout(mem_dout), .o_owner_busy(owner_busy),
    .o_lock_err(lock_err), .o_state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port memory, read data one cycle after mem_read
  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (mem_write) mem[mem_addr[7:0]] <= mem_din;
    if (mem_read) mem_dout <= mem[mem_addr[7:0]];
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int k, input logic we, input logic lock,
                        input logic [31:0] addr, input logic [31:0] data);
    req_we[k]             = we;
    req_lock[k]           = lock;
    req_addr[k*32 +: 32]  = addr;
    req_wdata[k*32 +: 32] = data;
  endtask

  task automatic mem_poke(input logic [7:0] addr, input logic [31:0] data);
    bk_we = 1'b1; bk_addr = addr; bk_data = data;
    tick;
    bk_we = 1'b0;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    n_cmp++; if (gnt !== 4'b0) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (rvalid !== 4'b0) begin n_bad++; $display("FAIL reset_rvalid: got %b want 0000", rvalid); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++; if ({mem_read, mem_write} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes: got %b want 00", {mem_read, mem_write}); end
    n_cmp++; if (mem_addr !== 32'h0 || mem_din !== 32'h0) begin n_bad++; $display("FAIL reset_bus: got %h/%h want 0/0", mem_addr, mem_din); end
    n_cmp++; if ({owner_busy, lock_err} !== 2'b00) begin n_bad++; $display("FAIL reset_lock: got %b want 00", {owner_busy, lock_err}); end
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_idle;
    req = 4'b0;
    for (int c = 0; c < 5; c++) begin
      tick;
      n_cmp++; if ({gnt, mem_read, mem_write} !== 6'b0) begin n_bad++; $display("FAIL idle_quiet: got %b want 000000", {gnt, mem_read, mem_write}); end
    end
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL idle_state: got %0d want 0", state); end
  endtask

  task automatic test_single_read;
    mem_poke(8'd5, 32'd9);
    set_op(1, 1'b0, 1'b0, 32'd5, 32'd0);
    req = 4'b0010;
    tick;
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL rd_gnt: got %b want 0010", gnt); end
    n_cmp++; if ({mem_read, mem_write} !== 2'b10) begin n_bad++; $display("FAIL rd_strobe: got %b want 10", {mem_read, mem_write}); end
    n_cmp++; if (mem_addr !== 32'd5) begin n_bad++; $display("FAIL rd_addr: got %0d want 5", mem_addr); end
    req = 4'b0;
    tick;
    n_cmp++; if ({gnt, rvalid, mem_read} !== 9'b0) begin n_bad++; $display("FAIL rd_wait_quiet: got %b want 0", {gnt, rvalid, mem_read}); end
    tick;
    n_cmp++; if (rvalid !== 4'b0010) begin n_bad++; $display("FAIL rd_rvalid: got %b want 0010", rvalid); end
    n_cmp++; if (rdata !== 32'd9) begin n_bad++; $display("FAIL rd_rdata: got %0d want 9", rdata); end
    tick;
    n_cmp++; if (rvalid !== 4'b0) begin n_bad++; $display("FAIL rd_rvalid_pulse: got %b want 0000", rvalid); end
    n_cmp++; if (rdata !== 32'd9) begin n_bad++; $display("FAIL rd_rdata_hold: got %0d want 9", rdata); end
  endtask

  task automatic test_round_robin;
    pulse_reset;
    for (int k = 0; k < 4; k++) set_op(k, 1'b1, 1'b0, 32'(k), 32'(10 + k));
    req = 4'b1111;
    n_g = 0;
    for (int i = 0; i < 8; i++) begin g_idx[i] = -1; g_cyc[i] = -1; g_din[i] = '0; end
    for (int c = 1; c <= 10; c++) begin
      tick;
      for (int k = 0; k < 4; k++) begin
        if (gnt[k]) begin
          if (n_g < 8) begin g_idx[n_g] = k; g_cyc[n_g] = c; g_din[n_g] = mem_din; end
          n_g++;
          req[k] = 1'b0;
        end
      end
    end
    n_cmp++; if (n_g !== 4) begin n_bad++; $display("FAIL rr_count: got %0d want 4", n_g); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (g_idx[i] !== i) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, g_idx[i], i); end
      n_cmp++; if (g_cyc[i] !== 2*i + 1) begin n_bad++; $display("FAIL rr_cycle[%0d]: got %0d want %0d", i, g_cyc[i], 2*i + 1); end
      n_cmp++; if (g_din[i] !== 32'(10 + i)) begin n_bad++; $display("FAIL rr_din[%0d]: got %0d want %0d", i, g_din[i], 10 + i); end
      n_cmp++; if (mem[i] !== 32'(10 + i)) begin n_bad++; $display("FAIL rr_mem[%0d]: got %0d want %0d", i, mem[i], 10 + i); end
    end
  endtask

  task automatic test_alternate;
    set_op(0, 1'b1, 1'b0, 32'd20, 32'd100);
    set_op(2, 1'b1, 1'b0, 32'd22, 32'd102);
    req = 4'b0101;
    n_g = 0;
    for (int i = 0; i < 8; i++) begin g_idx[i] = -1; g_cyc[i] = -1; end
    for (int c = 1; c <= 8; c++) begin
      tick;
      for (int k = 0; k < 4; k++) begin
        if (gnt[k]) begin
          if (n_g < 8) begin g_idx[n_g] = k; g_cyc[n_g] = c; end
          n_g++;
        end
      end
    end
    req = 4'b0;
    n_cmp++; if (n_g !== 4) begin n_bad++; $display("FAIL alt_count: got %0d want 4", n_g); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (g_idx[i] !== ((i % 2) * 2)) begin n_bad++; $display("FAIL alt_order[%0d]: got %0d want %0d", i, g_idx[i], (i % 2) * 2); end
      n_cmp++; if (g_cyc[i] !== 2*i + 1) begin n_bad++; $display("FAIL alt_cycle[%0d]: got %0d want %0d", i, g_cyc[i], 2*i + 1); end
    end
    tick;
    n_cmp++; if (gnt !== 4'b0) begin n_bad++; $display("FAIL alt_stop: got %b want 0000", gnt); end
    n_cmp++; if (mem[20] !== 32'd100 || mem[22] !== 32'd102) begin n_bad++; $display("FAIL alt_mem: got %0d/%0d want 100/102", mem[20], mem[22]); end
  endtask

  task automatic test_lock_claim;
    mem_poke(8'd17, 32'hFFFF_FFFF);
    pulse_reset;
    set_op(0, 1'b0, 1'b1, 32'd17, 32'd0);
    set_op(1, 1'b1, 1'b0, 32'd17, 32'd4);
    req = 4'b0011;
    tick; // t1
    n_cmp++; if (gnt !== 4'b0001 || mem_read !== 1'b1) begin n_bad++; $display("FAIL lk_rd_gnt: got %b/%b want 0001/1", gnt, mem_read); end
    req[0] = 1'b0;
    tick; // t2
    n_cmp++; if (gnt !== 4'b0) begin n_bad++; $display("FAIL lk_t2_gnt: got %b want 0000", gnt); end
    tick; // t3
    n_cmp++; if (rvalid !== 4'b0001 || rdata !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL lk_rd_resp: got %b/%h want 0001/ffffffff", rvalid, rdata); end
    set_op(0, 1'b1, 1'b0, 32'd17, 32'd5);
    req[0] = 1'b1;
    tick; // t4
    n_cmp++; if (owner_busy !== 1'b1 || state !== 3'd1) begin n_bad++; $display("FAIL lk_hold: got busy %b state %0d want 1/1", owner_busy, state); end
    n_cmp++; if (gnt !== 4'b0) begin n_bad++; $display("FAIL lk_t4_gnt: got %b want 0000", gnt); end
    tick; // t5
    n_cmp++; if (gnt !== 4'b0001 || mem_write !== 1'b1 || mem_din !== 32'd5) begin n_bad++; $display("FAIL lk_wr: got %b/%b/%0d want 0001/1/5", gnt, mem_write, mem_din); end
    n_cmp++; if (owner_busy !== 1'b1) begin n_bad++; $display("FAIL lk_busy_t5: got %b want 1", owner_busy); end
    req[0] = 1'b0;
    tick; // t6
    n_cmp++; if (owner_busy !== 1'b0 || gnt !== 4'b0) begin n_bad++; $display("FAIL lk_release: got busy %b gnt %b want 0/0000", owner_busy, gnt); end
    tick; // t7
    n_cmp++; if (gnt !== 4'b0010 || mem_din !== 32'd4) begin n_bad++; $display("FAIL lk_other: got %b/%0d want 0010/4", gnt, mem_din); end
    req[1] = 1'b0;
    tick;
    n_cmp++; if (mem[17] !== 32'd4) begin n_bad++; $display("FAIL lk_mem: got %0d want 4", mem[17]); end
  endtask

  task automatic test_reset_midread;
    set_op(2, 1'b0, 1'b0, 32'd3, 32'd0);
    req = 4'b0100;
    tick; // t1
    n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL rm_gnt: got %b want 0100", gnt); end
    req = 4'b0;
    tick; // t2
    rst_n = 1'b0;
    tick; // t3
    n_cmp++; if ({gnt, rvalid, mem_read, mem_write, owner_busy, lock_err} !== 12'b0) begin n_bad++; $display("FAIL rm_ctrl: got %b want 0", {gnt, rvalid, mem_read, mem_write, owner_busy, lock_err}); end
    n_cmp++; if (rdata !== 32'h0 || mem_addr !== 32'h0 || state !== 3'd0) begin n_bad++; $display("FAIL rm_data: got %h/%h/%0d want 0/0/0", rdata, mem_addr, state); end
    rst_n = 1'b1;
    set_op(0, 1'b1, 1'b0, 32'd40, 32'd7);
    set_op(3, 1'b1, 1'b0, 32'd43, 32'd8);
    req = 4'b1001;
    tick; // t4
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rm_first: got %b want 0001", gnt); end
    req[0] = 1'b0;
    tick; // t5
    n_cmp++; if (rvalid !== 4'b0 || gnt !== 4'b0) begin n_bad++; $display("FAIL rm_no_rvalid: got %b/%b want 0000/0000", rvalid, gnt); end
    tick; // t6
    n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL rm_second: got %b want 1000", gnt); end
    req = 4'b0;
    tick;
  endtask

  task automatic test_lock_timeout;
    pulse_reset;
    set_op(1, 1'b1, 1'b1, 32'd30, 32'd1);
    req = 4'b0010;
    tick; // t1
    n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL to_gnt1: got %b want 0010", gnt); end
    set_op(2, 1'b1, 1'b0, 32'd31, 32'd2);
    req = 4'b0100;
    tick; // t2: first HOLD cycle
    n_cmp++; if (owner_busy !== 1'b1 || state !== 3'd1) begin n_bad++; $display("FAIL to_hold: got busy %b state %0d want 1/1", owner_busy, state); end
`ifdef ARB_LOCK_TIMEOUT_EN
    for (int c = 3; c <= 12; c++) begin
      tick;
      n_cmp++; if (lock_err !== (c == 10)) begin n_bad++; $display("FAIL to_lock_err@%0d: got %b want %b", c, lock_err, (c == 10)); end
      n_cmp++; if (gnt !== ((c == 12) ? 4'b0100 : 4'b0000)) begin n_bad++; $display("FAIL to_gnt@%0d: got %b", c, gnt); end
      if (c == 11) begin
        n_cmp++; if (owner_busy !== 1'b0) begin n_bad++; $display("FAIL to_release: got %b want 0", owner_busy); end
      end
    end
`else
    for (int c = 3; c <= 32; c++) begin
      tick;
      n_cmp++; if (gnt !== 4'b0 || lock_err !== 1'b0) begin n_bad++; $display("FAIL to_held@%0d: got gnt %b err %b want 0000/0", c, gnt, lock_err); end
    end
    n_cmp++; if (owner_busy !== 1'b1) begin n_bad++; $display("FAIL to_still_busy: got %b want 1", owner_busy); end
`endif
    req = 4'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_we = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0; bk_we = 1'b0; bk_addr = '0; bk_data = '0;
    test_reset;
    test_idle;
    test_single_read;
    test_round_robin;
    test_alternate;
    test_lock_claim;
    test_reset_midread;
    test_lock_timeout;
    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
